muldiv_sequencer: RTL

- Multi-cycle multiply/divide controller owning the HI/LO register pair for the 32-bit MIPS-style core.
- Replaces the single-cycle combinational multiply/divide path with an iterative shift-add multiplier and a restoring divider sequenced by an FSM.
- Pipeline control issues an op and holds the pipeline while `busy` is high. MFHI/MFLO read the `hi`/`lo` outputs directly.

---
 rtl/muldiv_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative shift-add multiplier / restoring divider owning HI/LO.
// Optional: define MULDIV_DBZ_FLAG_EN to add a registered dbz output.
module muldiv_sequencer #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   alucontrol,
  input  logic         sign,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
`ifdef MULDIV_DBZ_FLAG_EN
  ,
  output logic         dbz
`endif
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;

  logic [1:0]     state;
  logic [CW-1:0]  cnt;
  logic           is_div;
  logic [N-1:0]   b_mag;
  logic [N-1:0]   a_mag;
  logic           neg_p;
  logic           neg_q;
  logic           neg_r;
  logic           dbz_q;
  logic [2*N-1:0] acc;
  logic [N:0]     rem;

  logic           op_ok;
  logic           accept;
  logic [N-1:0]   a_abs;
  logic [N-1:0]   b_abs;
  logic [N:0]     mul_sum;
  logic [N:0]     div_sh;
  logic [N:0]     div_diff;
  logic [2*N-1:0] prod;
  logic [N-1:0]   quo;
  logic [N-1:0]   rmd;
  logic [N-1:0]   a_back;

  assign op_ok  = (alucontrol == OP_MUL)
                | (alucontrol == OP_DIV);
  assign accept = (state == S_IDLE) & start & op_ok;

  assign a_abs = (sign & a[N-1])
               ? {N{1'b0}} - a : a;
  assign b_abs = (sign & b[N-1])
               ? {N{1'b0}} - b : b;

  // acc = {partial product, remaining multiplier bits}
  assign mul_sum = {1'b0, acc[2*N-1:N]}
                 + (acc[0] ? {1'b0, b_mag}
                           : {(N+1){1'b0}});

  // acc[N-1:0] shifts dividend bits out MSB-first
  // and quotient bits in at the LSB.
  assign div_sh   = {rem[N-1:0], acc[N-1]};
  assign div_diff = div_sh - {1'b0, b_mag};

  assign prod = neg_p ? {(2*N){1'b0}} - acc : acc;
  assign quo  = neg_q ? {N{1'b0}} - acc[N-1:0]
                      : acc[N-1:0];
  assign rmd  = neg_r ? {N{1'b0}} - rem[N-1:0]
                      : rem[N-1:0];
  assign a_back = neg_r ? {N{1'b0}} - a_mag : a_mag;

  assign busy = (state == S_CALC)
              | (state == S_FIXUP);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      a_mag  <= '0;
      b_mag  <= '0;
      neg_p  <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dbz_q  <= 1'b0;
      acc    <= '0;
      rem    <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            is_div <= (alucontrol == OP_DIV);
            a_mag  <= a_abs;
            b_mag  <= b_abs;
            neg_p  <= sign & (a[N-1] ^ b[N-1]);
            neg_q  <= sign & (a[N-1] ^ b[N-1]);
            neg_r  <= sign & a[N-1];
            dbz_q  <= (b == '0);
            acc    <= {{N{1'b0}}, a_abs};
            rem    <= '0;
            cnt    <= CW'(N - 1);
            state  <= S_CALC;
          end
        end
        S_CALC: begin
          if (is_div) begin
            if (!div_diff[N]) begin
              rem <= div_diff;
              acc <= {acc[2*N-1:N],
                      acc[N-2:0], 1'b1};
            end else begin
              rem <= div_sh;
              acc <= {acc[2*N-1:N],
                      acc[N-2:0], 1'b0};
            end
          end else begin
            acc <= {mul_sum, acc[N-1:1]};
          end
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= S_FIXUP;
        end
        S_FIXUP: begin
          if (!is_div) begin
            hi <= prod[2*N-1:N];
            lo <= prod[N-1:0];
          end else if (dbz_q) begin
            hi <= a_back;
            lo <= '1;
          end else begin
            hi <= rmd;
            lo <= quo;
          end
          state <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MULDIV_DBZ_FLAG_EN
  always_ff @(posedge clk) begin
    if (reset)
      dbz <= 1'b0;
    else if (state == S_FIXUP)
      dbz <= is_div & dbz_q;
  end
`endif

endmodule
